eva_mem_initiator: RTL

//  Bus initiator driving the rd/we/addr/wdata -> rdata memory port of EVA_MEM_WRAP from a testbench command stream.

---
 rtl/eva_mem_initiator.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/eva_mem_initiator.sv
// eva_mem_initiator: command-stream bus initiator for the EVA_MEM_WRAP memory port.
// Issues one registered memory op per accepted command. Reads are tracked through
// a RD_LAT-deep valid pipeline. Read data returns in order through a show-ahead FIFO.
// Optional feature macro: EVA_MINIT_CHK_EN (expected-data compare, rsp_err, err_cnt).
module eva_mem_initiator #(
    parameter int WIDTH     = 32,
    parameter int MASKBITS  = 1,
    parameter int RD_LAT    = 1,
    parameter int RSP_DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_wr,
    input  logic [31:0]         cmd_addr,
    input  logic [MASKBITS-1:0] cmd_wmsk,
    input  logic [WIDTH-1:0]    cmd_wdata,
`ifdef EVA_MINIT_CHK_EN
    input  logic [WIDTH-1:0]    cmd_exp,
`endif
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [WIDTH-1:0]    rsp_data,
`ifdef EVA_MINIT_CHK_EN
    output logic                rsp_err,
    output logic [15:0]         err_cnt,
`endif
    output logic                mem_rd,
    output logic [MASKBITS-1:0] mem_we,
    output logic [31:0]         mem_addr,
    output logic [WIDTH-1:0]    mem_wdata,
    input  logic [WIDTH-1:0]    mem_rdata,
    output logic                busy
);

    localparam int PW = $clog2(RSP_DEPTH);
    localparam int CW = PW + 1;

    logic                mem_rd_q,    mem_rd_d;
    logic [MASKBITS-1:0] mem_we_q,    mem_we_d;
    logic [31:0]         mem_addr_q,  mem_addr_d;
    logic [WIDTH-1:0]    mem_wdata_q, mem_wdata_d;
    logic [RD_LAT-1:0]   rd_sr_q,     rd_sr_d;
    logic [CW-1:0]       inflight_q,  inflight_d;
    logic [CW-1:0]       fifo_cnt_q,  fifo_cnt_d;
    logic [PW-1:0]       wr_ptr_q,    wr_ptr_d;
    logic [PW-1:0]       rd_ptr_q,    rd_ptr_d;
    logic [WIDTH-1:0]    fifo_data_q [RSP_DEPTH];
    logic [WIDTH-1:0]    fifo_data_d [RSP_DEPTH];

    logic          accept;
    logic          acc_rd;
    logic          push;
    logic          pop;
    logic [CW-1:0] occ;

    // Credit is taken from registered counters only, so a pop frees a slot one cycle later.
    assign occ       = inflight_q + fifo_cnt_q;
    assign cmd_ready = (occ < CW'(RSP_DEPTH));
    assign busy      = (occ != '0);
    assign accept    = cmd_valid & cmd_ready;
    assign acc_rd    = accept & ~cmd_wr;
    assign push      = rd_sr_q[RD_LAT-1];
    assign rsp_valid = (fifo_cnt_q != '0);
    assign pop       = rsp_valid & rsp_ready;
    assign rsp_data  = rsp_valid ? fifo_data_q[rd_ptr_q] : '0;
    assign mem_rd    = mem_rd_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

    // Next-state for the issue register, read-tracking pipeline, counters and FIFO pointers.
    always_comb begin
        mem_rd_d    = acc_rd;
        mem_we_d    = (accept && cmd_wr) ? cmd_wmsk : '0;
        mem_addr_d  = accept ? cmd_addr : mem_addr_q;
        mem_wdata_d = (accept && cmd_wr) ? cmd_wdata : mem_wdata_q;

        rd_sr_d    = '0;
        rd_sr_d[0] = mem_rd_q;
        for (int i = 1; i < RD_LAT; i++) begin
            rd_sr_d[i] = rd_sr_q[i-1];
        end

        inflight_d = inflight_q;
        if (acc_rd && !push) begin
            inflight_d = inflight_q + CW'(1);
        end else if (!acc_rd && push) begin
            inflight_d = inflight_q - CW'(1);
        end

        fifo_cnt_d = fifo_cnt_q;
        if (push && !pop) begin
            fifo_cnt_d = fifo_cnt_q + CW'(1);
        end else if (pop && !push) begin
            fifo_cnt_d = fifo_cnt_q - CW'(1);
        end

        wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    end

    // FIFO storage write; capacity is guaranteed by the credit rule.
    always_comb begin
        fifo_data_d = fifo_data_q;
        if (push) begin
            fifo_data_d[wr_ptr_q] = mem_rdata;
        end
    end

    // Control state with synchronous active-low reset that discards everything in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem_rd_q    <= 1'b0;
            mem_we_q    <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rd_sr_q     <= '0;
            inflight_q  <= '0;
            fifo_cnt_q  <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
        end else begin
            mem_rd_q    <= mem_rd_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rd_sr_q     <= rd_sr_d;
            inflight_q  <= inflight_d;
            fifo_cnt_q  <= fifo_cnt_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
        end
    end

    // Data-only storage needs no reset: it is only observed behind valid bits.
    always_ff @(posedge clk) begin
        fifo_data_q <= fifo_data_d;
    end

`ifdef EVA_MINIT_CHK_EN
    logic [WIDTH-1:0] exp_issue_q, exp_issue_d;
    logic [WIDTH-1:0] exp_sr_q    [RD_LAT];
    logic [WIDTH-1:0] exp_sr_d    [RD_LAT];
    logic [WIDTH-1:0] fifo_exp_q  [RSP_DEPTH];
    logic [WIDTH-1:0] fifo_exp_d  [RSP_DEPTH];
    logic [15:0]      err_cnt_q,  err_cnt_d;

    assign rsp_err = rsp_valid & (rsp_data != fifo_exp_q[rd_ptr_q]);
    assign err_cnt = err_cnt_q;

    // Expected data rides alongside each read through the tag pipeline into the FIFO.
    always_comb begin
        exp_issue_d = acc_rd ? cmd_exp : exp_issue_q;
        exp_sr_d    = exp_sr_q;
        exp_sr_d[0] = exp_issue_q;
        for (int i = 1; i < RD_LAT; i++) begin
            exp_sr_d[i] = exp_sr_q[i-1];
        end
        fifo_exp_d = fifo_exp_q;
        if (push) begin
            fifo_exp_d[wr_ptr_q] = exp_sr_q[RD_LAT-1];
        end
        err_cnt_d = err_cnt_q;
        if (pop && rsp_err && (err_cnt_q != 16'hFFFF)) begin
            err_cnt_d = err_cnt_q + 16'd1;
        end
    end

    // Compare storage follows the data path; only the mismatch counter is reset.
    always_ff @(posedge clk) begin
        exp_issue_q <= exp_issue_d;
        exp_sr_q    <= exp_sr_d;
        fifo_exp_q  <= fifo_exp_d;
        if (!rst_n) begin
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end
`else
    // Without the compare feature responses carry read data only.
`endif

endmodule
